// File: rtl/router_sched_pkg.sv
// Shared types and width helpers for the router output-port scheduler.
package router_sched_pkg;

    localparam int OWNER_REQ_W = 8;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int req_bits(input int num_ports, input int num_vc);
        return idx_bits(num_ports * num_vc);
    endfunction

    function automatic int cred_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_e;

    typedef struct packed {
        logic                   vld;
        logic [OWNER_REQ_W-1:0] req;
    } owner_rec_t;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder with a valid flag.
module priority_encoder
    import router_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the search starts at ptr_i, pointer storage lives in the parent.
module rr_arbiter
    import router_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_bits(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!valid_o && eligible_i[k]) begin
                valid_o    = 1'b1;
                idx_o      = IW'(k);
                grant_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_vc_scheduler.sv
// Per-output-port scheduler: packet-level downstream VC allocation, flit-level round-robin
// link arbitration, and credit gating. Grants are combinational; state moves at the next edge.
module output_vc_scheduler
    import router_sched_pkg::*;
#(
    parameter  int NUM_PORTS    = 5,
    parameter  int NUM_VC       = 4,
    parameter  int CREDIT_DEPTH = 1,
    localparam int NUM_REQ      = NUM_PORTS * NUM_VC,
    localparam int REQ_BITS     = req_bits(NUM_PORTS, NUM_VC),
    localparam int VC_BITS      = idx_bits(NUM_VC),
    localparam int CRED_BITS    = cred_bits(CREDIT_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  req_tail,
    input  logic                credit_in_valid,
    input  logic [VC_BITS-1:0]  credit_in_vc,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_valid,
    output logic [REQ_BITS-1:0] grant_idx,
    output logic [VC_BITS-1:0]  grant_out_vc,
    output logic [NUM_VC-1:0]   vc_busy,
    output logic                credit_error
);

    logic [CRED_BITS-1:0] credits_q [NUM_VC];
    logic [CRED_BITS-1:0] credits_d [NUM_VC];
    owner_rec_t           owner_q   [NUM_VC];
    logic [NUM_REQ-1:0]   own_vld_q;
    logic [VC_BITS-1:0]   own_vc_q  [NUM_REQ];
    logic [REQ_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic                 credit_error_q, credit_error_d;

    vc_state_e            vc_state  [NUM_VC];
    logic [NUM_VC-1:0]    free_vec;
    logic [VC_BITS-1:0]   free_vc;
    logic                 free_any;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [REQ_BITS-1:0]  arb_idx;
    logic                 arb_valid;
    logic                 win_owns, win_tail;
    logic [VC_BITS-1:0]   tgt_vc;
    logic [NUM_VC-1:0]    dec_vec, inc_vec;

    // A VC can take a new packet only when unowned and holding at least one credit.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_state[v] = owner_q[v].vld ? VC_ACTIVE : VC_IDLE;
            free_vec[v] = (vc_state[v] == VC_IDLE) && (credits_q[v] != '0);
            vc_busy[v]  = (vc_state[v] == VC_ACTIVE);
        end
    end

    priority_encoder #(.N(NUM_VC)) u_free_vc (
        .req_i   (free_vec),
        .idx_o   (free_vc),
        .valid_o (free_any)
    );

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            eligible[r] = req[r] &&
                          (own_vld_q[r] ? (credits_q[own_vc_q[r]] != '0) : free_any);
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (arb_grant),
        .idx_o      (arb_idx),
        .valid_o    (arb_valid)
    );

    assign win_owns = own_vld_q[arb_idx];
    assign win_tail = req_tail[arb_idx];
    assign tgt_vc   = win_owns ? own_vc_q[arb_idx] : free_vc;

    // A same-cycle grant and credit return on one VC cancel; only a lone return can overflow.
    always_comb begin
        credit_error_d = credit_error_q;
        for (int v = 0; v < NUM_VC; v++) begin
            dec_vec[v]   = arb_valid && (tgt_vc == VC_BITS'(v));
            inc_vec[v]   = credit_in_valid && (credit_in_vc == VC_BITS'(v));
            credits_d[v] = credits_q[v];
            if (dec_vec[v] && !inc_vec[v]) begin
                credits_d[v] = credits_q[v] - CRED_BITS'(1);
            end else if (inc_vec[v] && !dec_vec[v]) begin
                if (credits_q[v] == CRED_BITS'(CREDIT_DEPTH)) begin
                    credit_error_d = 1'b1;
                end else begin
                    credits_d[v] = credits_q[v] + CRED_BITS'(1);
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (arb_valid) begin
            rr_ptr_d = (arb_idx == REQ_BITS'(NUM_REQ - 1)) ? '0 : arb_idx + REQ_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credits_q[v] <= CRED_BITS'(CREDIT_DEPTH);
            end
            rr_ptr_q       <= '0;
            credit_error_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                credits_q[v] <= credits_d[v];
            end
            rr_ptr_q       <= rr_ptr_d;
            credit_error_q <= credit_error_d;
        end
    end

    // Per-VC ownership FSM. Single-flit packets pass through IDLE without taking a lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                owner_q[v] <= '0;
            end
            own_vld_q <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                own_vc_q[r] <= '0;
            end
        end else if (arb_valid) begin
            for (int v = 0; v < NUM_VC; v++) begin
                case (vc_state[v])
                    VC_IDLE: begin
                        if (!win_owns && !win_tail && (free_vc == VC_BITS'(v))) begin
                            owner_q[v]         <= '{vld: 1'b1, req: OWNER_REQ_W'(arb_idx)};
                            own_vld_q[arb_idx] <= 1'b1;
                            own_vc_q[arb_idx]  <= VC_BITS'(v);
                        end
                    end
                    VC_ACTIVE: begin
                        if (win_owns && win_tail && (owner_q[v].req == OWNER_REQ_W'(arb_idx))) begin
                            owner_q[v].vld     <= 1'b0;
                            own_vld_q[arb_idx] <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign grant        = reset ? arb_grant : '0;
    assign grant_valid  = reset && arb_valid;
    assign grant_idx    = reset ? arb_idx : '0;
    assign grant_out_vc = (reset && arb_valid) ? tgt_vc : '0;
    assign credit_error = credit_error_q;

endmodule

// File: tb/tb_output_vc_scheduler.sv
// Directed and randomized checks of output_vc_scheduler against a queue/array reference model.
module tb_output_vc_scheduler;

    localparam int NP = 5;
    localparam int NV = 4;
    localparam int D  = 2;
    localparam int NR = NP * NV;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] req_tail;
    logic          credit_in_valid;
    logic [1:0]    credit_in_vc;
    logic [NR-1:0] grant;
    logic          grant_valid;
    logic [4:0]    grant_idx;
    logic [1:0]    grant_out_vc;
    logic [NV-1:0] vc_busy;
    logic          credit_error;

    output_vc_scheduler #(
        .NUM_PORTS    (NP),
        .NUM_VC       (NV),
        .CREDIT_DEPTH (D)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_tail        (req_tail),
        .credit_in_valid (credit_in_valid),
        .credit_in_vc    (credit_in_vc),
        .grant           (grant),
        .grant_valid     (grant_valid),
        .grant_idx       (grant_idx),
        .grant_out_vc    (grant_out_vc),
        .vc_busy         (vc_busy),
        .credit_error    (credit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner of each VC (-1 free), VC held by each requester (-1 none).
    int m_cred  [NV];
    int m_vcown [NV];
    int m_own   [NR];
    int m_ptr;
    bit m_err;

    int n_cmp;
    int n_fail;
    logic       obs_valid;
    logic [4:0] obs_idx;
    logic [1:0] obs_vc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_cred[v]  = D;
            m_vcown[v] = -1;
        end
        for (int r = 0; r < NR; r++) m_own[r] = -1;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic model_pick(input logic [NR-1:0] r, output int w, output int tv);
        int fv;
        int rr;
        w  = -1;
        tv = 0;
        fv = -1;
        for (int v = 0; v < NV; v++)
            if (fv < 0 && m_vcown[v] < 0 && m_cred[v] > 0) fv = v;
        for (int i = 0; i < NR; i++) begin
            rr = (m_ptr + i) % NR;
            if (w < 0 && r[rr]) begin
                if (m_own[rr] >= 0 ? (m_cred[m_own[rr]] > 0) : (fv >= 0)) w = rr;
            end
        end
        if (w >= 0) tv = (m_own[w] >= 0) ? m_own[w] : fv;
    endtask

    task automatic model_update(input logic [NR-1:0] t, input logic cv, input int cvc,
                                input int w, input int tv);
        if (w >= 0) begin
            m_cred[tv]--;
            if (m_own[w] >= 0) begin
                if (t[w]) begin
                    m_vcown[m_own[w]] = -1;
                    m_own[w] = -1;
                end
            end else if (!t[w]) begin
                m_vcown[tv] = w;
                m_own[w]    = tv;
            end
            m_ptr = (w + 1) % NR;
        end
        if (cv) begin
            if (m_cred[cvc] == D) m_err = 1'b1;
            else m_cred[cvc]++;
        end
    endtask

    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] t,
                        input logic cv, input logic [1:0] cvc);
        int w;
        int tv;
        logic [NR-1:0] eg;
        logic [NV-1:0] eb;
        req = r;
        req_tail = t;
        credit_in_valid = cv;
        credit_in_vc = cvc;
        model_pick(r, w, tv);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        for (int v = 0; v < NV; v++) eb[v] = (m_vcown[v] >= 0);
        @(negedge clk);
        chk("grant_valid", 32'(grant_valid), 32'(w >= 0));
        chk("grant", 32'(grant), 32'(eg));
        if (w >= 0) begin
            chk("grant_idx", 32'(grant_idx), 32'(w));
            chk("grant_out_vc", 32'(grant_out_vc), 32'(tv));
        end
        chk("vc_busy", 32'(vc_busy), 32'(eb));
        chk("credit_error", 32'(credit_error), 32'(m_err));
        obs_valid = grant_valid;
        obs_idx   = grant_idx;
        obs_vc    = grant_out_vc;
        @(posedge clk);
        model_update(t, cv, int'(cvc), w, tv);
        #1;
    endtask

    task automatic do_reset();
        req   = '1;
        reset = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_vc_busy", 32'(vc_busy), 32'd0);
        chk("rst_credit_error", 32'(credit_error), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b0;
        req = '1;
        req_tail = '0;
        credit_in_valid = 1'b0;
        credit_in_vc = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_grant", 32'(grant), 32'd0);
            chk("rst_hold_busy", 32'(vc_busy), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req = '0;

        // First head flit takes VC0 and locks it.
        step(20'(1) << 3, '0, 1'b0, 2'd0);
        chk("s1_idx", 32'(obs_idx), 32'd3);
        chk("s1_vc", 32'(obs_vc), 32'd0);
        chk("s1_busy", 32'(vc_busy), 32'b0001);

        // Reset mid-packet clears the lock at once and returns the pointer to 0.
        do_reset();

        // Single-flit alternation between 0 and 5 with credits returned each cycle.
        for (int i = 0; i < 4; i++) begin
            step((20'(1) << 0) | (20'(1) << 5), (20'(1) << 0) | (20'(1) << 5), 1'b1, 2'd0);
            chk("alt_idx", 32'(obs_idx), (i % 2 == 0) ? 32'd0 : 32'd5);
        end
        step(20'(1) << 19, 20'(1) << 19, 1'b1, 2'd0);
        chk("wrap19_idx", 32'(obs_idx), 32'd19);
        step((20'(1) << 0) | (20'(1) << 19), (20'(1) << 0) | (20'(1) << 19), 1'b1, 2'd0);
        chk("wrap0_idx", 32'(obs_idx), 32'd0);
        do_reset();

        // Blocked owner never blocks another requester.
        step(20'(1) << 2, '0, 1'b0, 2'd0);
        step(20'(1) << 2, '0, 1'b0, 2'd0);
        step((20'(1) << 2) | (20'(1) << 7), 20'(1) << 7, 1'b0, 2'd0);
        chk("blk_idx7", 32'(obs_idx), 32'd7);
        chk("blk_vc1", 32'(obs_vc), 32'd1);
        step(20'(1) << 2, '0, 1'b0, 2'd0);
        chk("blk_none", 32'(obs_valid), 32'd0);
        step(20'(1) << 2, '0, 1'b1, 2'd0);
        chk("blk_none2", 32'(obs_valid), 32'd0);
        step(20'(1) << 2, 20'(1) << 2, 1'b0, 2'd0);
        chk("blk_resume_idx", 32'(obs_idx), 32'd2);
        chk("blk_resume_vc", 32'(obs_vc), 32'd0);
        do_reset();

        // All four VCs locked; requester 10 waits for a tail to free one.
        for (int i = 0; i < 4; i++) begin
            step(20'(1) << i, '0, 1'b0, 2'd0);
            chk("fill_vc", 32'(obs_vc), 32'(i));
        end
        chk("fill_busy", 32'(vc_busy), 32'hf);
        step(20'(1) << 10, '0, 1'b0, 2'd0);
        chk("full_none", 32'(obs_valid), 32'd0);
        step((20'(1) << 10) | (20'(1) << 1), 20'(1) << 1, 1'b1, 2'd1);
        chk("tail_idx", 32'(obs_idx), 32'd1);
        step(20'(1) << 10, '0, 1'b0, 2'd0);
        chk("freed_idx", 32'(obs_idx), 32'd10);
        chk("freed_vc", 32'(obs_vc), 32'd1);
        do_reset();

        // Credit overflow is sticky; grant+return on VC2 leaves its count unchanged.
        step('0, '0, 1'b1, 2'd1);
        chk("ovf_err", 32'(credit_error), 32'd1);
        step(20'(1) << 0, '0, 1'b0, 2'd0);
        step(20'(1) << 1, '0, 1'b0, 2'd0);
        step(20'(1) << 4, 20'(1) << 4, 1'b1, 2'd2);
        chk("vc2_a", 32'(obs_vc), 32'd2);
        step(20'(1) << 4, 20'(1) << 4, 1'b0, 2'd0);
        chk("vc2_b", 32'(obs_vc), 32'd2);
        step(20'(1) << 4, 20'(1) << 4, 1'b0, 2'd0);
        chk("vc2_c", 32'(obs_vc), 32'd2);
        step(20'(1) << 4, 20'(1) << 4, 1'b0, 2'd0);
        chk("vc3_after", 32'(obs_vc), 32'd3);
        chk("err_sticky", 32'(credit_error), 32'd1);
        do_reset();

        // Randomized traffic against the model.
        for (int blk = 0; blk < 5; blk++) begin
            for (int c = 0; c < 120; c++) begin
                step(NR'($urandom & $urandom), NR'($urandom),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
